button_debouncer: RTL and testbench

//   Front-end conditioning for the board push-buttons, in NBTN independent channels.

---
 rtl/btn_pkg.sv | 13 +
 rtl/debounce_channel.sv | 101 ++++++++++
 rtl/button_debouncer.sv | 48 ++++
 tb/tb_button_debouncer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning front end.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE_HI = 2'd0,
        CHK_LO  = 2'd1,
        IDLE_LO = 2'd2,
        CHK_HI  = 2'd3
    } chan_state_e;

    localparam int DEBOUNCE_10MS_50MHZ = 500000;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, stability counter and a 4-state
// accept FSM producing a registered active-low clean level.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_10MS_50MHZ,
    parameter int CNT_W         = 19
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Raw,
    output logic Clean,
    output logic Checking
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             clean_q, clean_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    chan_state_e      state_q, state_d;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            clean_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE_HI;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        s1_d    = Raw;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        unique case (state_q)
            IDLE_HI: begin
                clean_d = 1'b1;
                if (!s2_q) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            CHK_LO: begin
                // Any reversal throws away all accumulated credit.
                if (s2_q) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LO;
                    clean_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            IDLE_LO: begin
                clean_d = 1'b0;
                if (s2_q) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            CHK_HI: begin
                if (!s2_q) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HI;
                    clean_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE_HI;
                clean_d = 1'b1;
                cnt_d   = '0;
            end
        endcase
    end

    assign Clean    = clean_q;
    assign Checking = (state_q == CHK_LO) || (state_q == CHK_HI);

endmodule

// File: rtl/button_debouncer.sv
// NBTN independent debounce channels plus a registered any-channel-checking flag.
module button_debouncer
    import btn_pkg::*;
#(
    parameter int NBTN          = 4,
    parameter int STABLE_CYCLES = DEBOUNCE_10MS_50MHZ,
    parameter int CNT_W         = 19
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [NBTN-1:0] BtnRaw,
    output logic [NBTN-1:0] BtnClean,
    output logic            Busy
);

    // The counter must be able to hold STABLE_CYCLES-1.
    if ((64'd1 << CNT_W) <= 64'(STABLE_CYCLES)) begin : g_bad_cnt_w
        $error("button_debouncer: CNT_W too small for STABLE_CYCLES");
    end

    logic [NBTN-1:0] checking;
    logic            busy_q, busy_d;

    for (genvar i = 0; i < NBTN; i++) begin : g_chan
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_chan (
            .Clock   (Clock),
            .Reset   (Reset),
            .Raw     (BtnRaw[i]),
            .Clean   (BtnClean[i]),
            .Checking(checking[i])
        );
    end

    always_comb begin
        busy_d = |checking;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) busy_q <= 1'b0;
        else        busy_q <= busy_d;
    end

    assign Busy = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=4, CNT_W=3.
module tb_button_debouncer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [3:0] BtnRaw = 4'b1111;
    logic [3:0] BtnClean;
    logic       Busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clock = ~Clock;

    button_debouncer #(
        .NBTN         (4),
        .STABLE_CYCLES(4),
        .CNT_W        (3)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .BtnRaw  (BtnRaw),
        .BtnClean(BtnClean),
        .Busy    (Busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle; "after Ek" means after this returns k+1 times.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        int toggles;
        logic prev;

        // 1. Reset held with all buttons "pressed" at the pins
        BtnRaw = 4'b0000;
        Reset  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_clean", {4'b0, BtnClean}, 8'h0F);
            chk("rst_busy", {7'b0, Busy}, 8'h00);
        end
        BtnRaw = 4'b1111;
        Reset  = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("idle_clean", {4'b0, BtnClean}, 8'h0F);
        chk("idle_busy", {7'b0, Busy}, 8'h00);

        // 2. Clean press on ch0
        BtnRaw[0] = 1'b0;
        tick(); tick(); tick(); tick();               // after E3
        chk("press_busy_e3", {7'b0, Busy}, 8'h01);
        tick();                                       // after E4
        chk("press_e4", {7'b0, BtnClean[0]}, 8'h01);
        tick();                                       // after E5
        chk("press_e5", {7'b0, BtnClean[0]}, 8'h00);
        tick();                                       // after E6
        chk("press_busy_e6", {7'b0, Busy}, 8'h00);

        // 3. Bounce on ch1: low E0,E1; high E2; low E3,E4; high after
        BtnRaw[1] = 1'b0;
        for (int e = 0; e <= 10; e++) begin
            tick();
            if (e == 1) BtnRaw[1] = 1'b1;
            if (e == 2) BtnRaw[1] = 1'b0;
            if (e == 4) BtnRaw[1] = 1'b1;
            chk($sformatf("bounce_clean_e%0d", e), {7'b0, BtnClean[1]}, 8'h01);
            if (e == 4) chk("bounce_busy_e4", {7'b0, Busy}, 8'h01);
            if (e == 5) chk("bounce_busy_e5", {7'b0, Busy}, 8'h00);
            if (e == 6) chk("bounce_busy_e6", {7'b0, Busy}, 8'h01);
            if (e == 8) chk("bounce_busy_e8", {7'b0, Busy}, 8'h00);
        end

        // 4. Release ch0: exactly one toggle, at E5
        BtnRaw[0] = 1'b1;
        toggles = 0;
        prev = BtnClean[0];
        for (int e = 0; e <= 12; e++) begin
            tick();
            if (BtnClean[0] !== prev) toggles++;
            prev = BtnClean[0];
            if (e == 4) chk("release_e4", {7'b0, BtnClean[0]}, 8'h00);
            if (e == 5) chk("release_e5", {7'b0, BtnClean[0]}, 8'h01);
        end
        chk("release_toggles", 8'(toggles), 8'd1);

        // 5. ch2 and ch3 fall together; ch3 bounces high at E2 only
        BtnRaw[3:2] = 2'b00;
        for (int e = 0; e <= 8; e++) begin
            tick();
            if (e == 1) BtnRaw[3] = 1'b1;
            if (e == 2) BtnRaw[3] = 1'b0;
            if (e == 4) chk("simul_e4", {4'b0, BtnClean}, 8'h0F);
            if (e == 5) chk("simul_e5", {4'b0, BtnClean}, 8'h0B);
            if (e == 7) chk("simul_e7", {4'b0, BtnClean}, 8'h0B);
            if (e == 8) chk("simul_e8", {4'b0, BtnClean}, 8'h03);
        end
        BtnRaw[3:2] = 2'b11;
        for (int i = 0; i < 10; i++) tick();
        chk("simul_release", {4'b0, BtnClean}, 8'h0F);

        // 6. Reset at E3 during ch0 check; raw stays low
        BtnRaw[0] = 1'b0;
        tick(); tick(); tick();                       // after E2
        chk("midrst_busy_pre", {7'b0, Busy}, 8'h00);
        Reset = 1'b0;
        tick();                                       // after E3 (reset edge)
        chk("midrst_clean", {7'b0, BtnClean[0]}, 8'h01);
        chk("midrst_busy", {7'b0, Busy}, 8'h00);
        Reset = 1'b1;
        tick(); tick(); tick(); tick(); tick();       // after E8
        chk("midrst_e8", {7'b0, BtnClean[0]}, 8'h01);
        tick();                                       // after E9
        chk("midrst_e9", {7'b0, BtnClean[0]}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
